// File: rtl/segway_stim_pkg.sv
// rtl/segway_stim_pkg.sv - shared types and constants for the Segway stimulus sequencer
package segway_stim_pkg;

  localparam int NUM_CH  = 6;
  localparam int CH_W    = 16;
  localparam int DWELL_W = 24;
  localparam int MON_W   = 16;

  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_S = 8'h53;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SEND,
    DWELL,
    DONE
  } state_t;

  typedef struct packed {
    logic [NUM_CH*CH_W-1:0] ch_val;
    logic [7:0]             cmd;
    logic                   send;
    logic [DWELL_W-1:0]     dwell;
    logic                   chk;
    logic                   last;
  } step_t;

endpackage

// File: rtl/stim_window_chk.sv
// rtl/stim_window_chk.sv - signed window compare of mon against target+/-tol, saturating fail counter
module stim_window_chk
  import segway_stim_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    chk_en,
  input  logic                    clr,
  input  logic signed [MON_W-1:0] mon,
  input  logic signed [MON_W-1:0] target,
  input  logic        [MON_W-1:0] tol,
  output logic        [7:0]       fail_cnt
);

  logic [MON_W:0] diff;
  logic [MON_W:0] abs_diff;
  logic           out_of_win;
  logic [7:0]     fail_cnt_d;
  logic [7:0]     fail_cnt_q;

  // One extra bit keeps mon-target exact over the full signed range.
  always_comb begin
    diff       = {mon[MON_W-1], mon} - {target[MON_W-1], target};
    abs_diff   = diff[MON_W] ? (~diff + 1'b1) : diff;
    out_of_win = abs_diff > {1'b0, tol};
    fail_cnt_d = fail_cnt_q;
    if (clr) begin
      fail_cnt_d = '0;
    end else if (chk_en && out_of_win && (fail_cnt_q != 8'hFF)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;

endmodule

// File: rtl/segway_stim_seq.sv
// rtl/segway_stim_seq.sv - table-driven stimulus/check sequencer for Segway bring-up and HIL runs
module segway_stim_seq
  import segway_stim_pkg::*;
#(
  parameter  int NUM_STEPS = 16,
  parameter  int TX_TO     = 65536,
  localparam int ADDR_W    = $clog2(NUM_STEPS),
  localparam int TO_W      = $clog2(TX_TO + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*CH_W-1:0]   wr_ch_val,
  input  logic [7:0]               wr_cmd,
  input  logic                     wr_send,
  input  logic [DWELL_W-1:0]       wr_dwell,
  input  logic                     wr_chk,
  input  logic                     wr_last,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop,
  input  logic signed [MON_W-1:0]  mon,
  input  logic signed [MON_W-1:0]  target,
  input  logic        [MON_W-1:0]  tol,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic [NUM_CH*CH_W-1:0]   ch_out,
  output logic [ADDR_W-1:0]        step_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               fail_cnt,
  output logic                     tx_err
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TX_TO - 1);

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]     cnt_q, cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [NUM_CH*CH_W-1:0] ch_out_q, ch_out_d;
  logic                   trmt_q, trmt_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_err_q, tx_err_d;
  logic                   chk_en;
  logic                   fail_clr;
  logic                   wr_ok;

  step_t table_q [NUM_STEPS];
  step_t entry;
  step_t wr_step;

  assign wr_ok = wr_en && ((state_q == IDLE) || (state_q == DONE));
  assign entry = table_q[step_idx_q];

  always_comb begin
    wr_step.ch_val = wr_ch_val;
    wr_step.cmd    = wr_cmd;
    wr_step.send   = wr_send;
    wr_step.dwell  = wr_dwell;
    wr_step.chk    = wr_chk;
    wr_step.last   = wr_last;
  end

  // Table is deliberately not reset so a loaded script survives a reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      table_q[wr_addr] <= wr_step;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    cnt_d      = cnt_q;
    to_cnt_d   = to_cnt_q;
    ch_out_d   = ch_out_q;
    trmt_d     = 1'b0;
    tx_data_d  = tx_data_q;
    tx_err_d   = tx_err_q;
    chk_en     = 1'b0;
    fail_clr   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = APPLY;
            step_idx_d = '0;
            tx_err_d   = 1'b0;
            fail_clr   = 1'b1;
          end
        end
        APPLY: begin
          ch_out_d = entry.ch_val;
          cnt_d    = entry.dwell;
          to_cnt_d = '0;
          if (entry.send) begin
            state_d   = SEND;
            trmt_d    = 1'b1;
            tx_data_d = entry.cmd;
          end else begin
            state_d = DWELL;
          end
        end
        SEND: begin
          if (tx_done) begin
            state_d = DWELL;
          end else if (to_cnt_q == TO_MAX) begin
            tx_err_d = 1'b1;
            state_d  = DWELL;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        DWELL: begin
          // dwell of 0 and 1 both end here on the first DWELL cycle
          if (cnt_q > DWELL_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d  = '0;
            chk_en = entry.chk;
            if (!entry.last) begin
              step_idx_d = step_idx_q + 1'b1;
              state_d    = APPLY;
            end else if (loop) begin
              step_idx_d = '0;
              state_d    = APPLY;
            end else begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_idx_q <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      ch_out_q   <= '0;
      trmt_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_idx_q <= step_idx_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      ch_out_q   <= ch_out_d;
      trmt_q     <= trmt_d;
      tx_data_q  <= tx_data_d;
      tx_err_q   <= tx_err_d;
    end
  end

  stim_window_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .chk_en   (chk_en),
    .clr      (fail_clr),
    .mon      (mon),
    .target   (target),
    .tol      (tol),
    .fail_cnt (fail_cnt)
  );

  assign trmt     = trmt_q;
  assign tx_data  = tx_data_q;
  assign ch_out   = ch_out_q;
  assign step_idx = step_idx_q;
  assign tx_err   = tx_err_q;
  assign busy     = (state_q == APPLY) || (state_q == SEND) || (state_q == DWELL);
  assign done     = (state_q == DONE);
  assign pass     = (fail_cnt == 8'd0) && !tx_err_q;

endmodule

// File: tb/tb_segway_stim_seq.sv
// tb/tb_segway_stim_seq.sv - directed self-checking bench for segway_stim_seq
module tb_segway_stim_seq;
  import segway_stim_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    wr_en = 1'b0;
  logic [3:0]              wr_addr = '0;
  logic [95:0]             wr_ch_val = '0;
  logic [7:0]              wr_cmd = '0;
  logic                    wr_send = 1'b0;
  logic [23:0]             wr_dwell = '0;
  logic                    wr_chk = 1'b0;
  logic                    wr_last = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    loop = 1'b0;
  logic signed [15:0]      mon = '0;
  logic signed [15:0]      target = '0;
  logic        [15:0]      tol = '0;
  logic                    tx_done = 1'b0;
  logic                    trmt;
  logic [7:0]              tx_data;
  logic [95:0]             ch_out;
  logic [3:0]              step_idx;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [7:0]              fail_cnt;
  logic                    tx_err;

  int n_assert = 0;
  int n_fail = 0;
  int pulses;

  segway_stim_seq dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_ch_val(wr_ch_val),
    .wr_cmd(wr_cmd), .wr_send(wr_send), .wr_dwell(wr_dwell), .wr_chk(wr_chk),
    .wr_last(wr_last), .start(start), .abort(abort), .loop(loop), .mon(mon),
    .target(target), .tol(tol), .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .ch_out(ch_out), .step_idx(step_idx), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mkch(input logic [15:0] c0);
    return {~c0, ~c0 ^ 16'h0F0F, 16'hA5A5, c0 ^ 16'h00FF, 16'h0003, c0};
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] c0, input logic [7:0] cmd,
                      input logic snd, input logic [23:0] dw, input logic ck, input logic lst);
    wr_addr = a; wr_ch_val = mkch(c0); wr_cmd = cmd; wr_send = snd;
    wr_dwell = dw; wr_chk = ck; wr_last = lst; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] idx, input int budget, input string tag);
    int n = 0;
    while (step_idx !== idx && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, step_idx, idx);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b1);
    check("rst_fail_cnt", fail_cnt, 8'd0);
    check("rst_tx_err", tx_err, 1'b0);
    check("rst_trmt", trmt, 1'b0);
    check("rst_ch_out", ch_out, 96'd0);
    check("rst_step_idx", step_idx, 4'd0);

    // Two-step run: APPLY at cycle 1, DWELL 10 + APPLY + DWELL 5, DONE at cycle 18.
    load(4'd0, 16'h0300, 8'h00, 1'b0, 24'd10, 1'b0, 1'b0);
    load(4'd1, 16'h0FFF, 8'h00, 1'b0, 24'd5, 1'b0, 1'b1);
    kick();
    check("t1_ch_before_apply", ch_out, 96'd0);
    check("t1_busy", busy, 1'b1);
    for (int c = 2; c <= 18; c++) begin
      @(negedge clk);
      if (c == 2)  check("t1_ch_step0", ch_out, mkch(16'h0300));
      if (c == 12) check("t1_ch_hold", ch_out, mkch(16'h0300));
      if (c == 12) check("t1_idx1", step_idx, 4'd1);
      if (c == 13) check("t1_ch_step1", ch_out, mkch(16'h0FFF));
      if (c == 17) check("t1_done_early", done, 1'b0);
      if (c == 18) check("t1_done_at_18", done, 1'b1);
    end
    check("t1_pass", pass, 1'b1);

    // UART send: single trmt pulse, dwell starts after tx_done.
    load(4'd0, 16'h0042, CMD_G, 1'b1, 24'd3, 1'b0, 1'b1);
    kick();
    @(negedge clk);
    check("t2_trmt", trmt, 1'b1);
    check("t2_tx_data", tx_data, 8'h47);
    pulses = int'(trmt);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pulses += int'(trmt);
    end
    check("t2_busy_waiting", busy, 1'b1);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    pulses += int'(trmt);
    @(negedge clk);
    @(negedge clk);
    check("t2_dwell3_not_done", done, 1'b0);
    @(negedge clk);
    check("t2_done_after_dwell", done, 1'b1);
    check("t2_trmt_pulses", pulses, 96'd1);
    check("t2_tx_err", tx_err, 1'b0);

    // Window checks around target 150 +/- 200, boundary inclusive.
    target = 16'sd150; tol = 16'd200; mon = 16'sd400;
    load(4'd0, 16'h0010, 8'h00, 1'b0, 24'd4, 1'b1, 1'b0);
    load(4'd1, 16'h0011, 8'h00, 1'b0, 24'd4, 1'b1, 1'b0);
    load(4'd2, 16'h0012, 8'h00, 1'b0, 24'd4, 1'b1, 1'b0);
    load(4'd3, 16'h0013, 8'h00, 1'b0, 24'd4, 1'b1, 1'b1);
    kick();
    wait_idx(4'd1, 20, "t3_reach_idx1");
    check("t3_fail_400", fail_cnt, 8'd1);
    mon = -16'sd100;
    wait_idx(4'd2, 20, "t3_reach_idx2");
    check("t3_fail_neg100", fail_cnt, 8'd2);
    mon = 16'sd350;
    wait_idx(4'd3, 20, "t3_reach_idx3");
    check("t3_edge_350", fail_cnt, 8'd2);
    mon = -16'sd50;
    wait_done(20, "t3_done");
    check("t3_edge_neg50", fail_cnt, 8'd2);
    check("t3_pass", pass, 1'b0);

    // tx_done never arrives: tx_err after TX_TO cycles in SEND, then DONE.
    load(4'd0, 16'h0077, CMD_S, 1'b1, 24'd2, 1'b0, 1'b1);
    kick();
    check("t4_fail_cleared", fail_cnt, 8'd0);
    @(negedge clk);
    check("t4_trmt", trmt, 1'b1);
    check("t4_tx_data", tx_data, 8'h53);
    repeat (65535) @(negedge clk);
    check("t4_no_err_yet", tx_err, 1'b0);
    @(negedge clk);
    check("t4_tx_err", tx_err, 1'b1);
    wait_done(10, "t4_done");
    check("t4_pass", pass, 1'b0);

    // Looping, abort mid-DWELL, writes dropped while busy.
    load(4'd0, 16'h1111, 8'h00, 1'b0, 24'd3, 1'b0, 1'b0);
    load(4'd1, 16'h2222, 8'h00, 1'b0, 24'd3, 1'b0, 1'b0);
    load(4'd2, 16'h3333, 8'h00, 1'b0, 24'd3, 1'b0, 1'b1);
    loop = 1'b1;
    kick();
    check("t5_tx_err_cleared", tx_err, 1'b0);
    wait_idx(4'd1, 20, "t5_idx1");
    wait_idx(4'd2, 20, "t5_idx2");
    wait_idx(4'd0, 20, "t5_wrap_idx0");
    check("t5_still_busy", busy, 1'b1);
    wait_idx(4'd1, 20, "t5_idx1_again");
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_idle", busy, 1'b0);
    check("t5_abort_not_done", done, 1'b0);
    check("t5_abort_ch_hold", ch_out, mkch(16'h2222));
    check("t5_abort_trmt", trmt, 1'b0);
    kick();
    load(4'd0, 16'hDEAD, 8'h00, 1'b0, 24'd1, 1'b0, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    loop = 1'b0;
    kick();
    @(negedge clk);
    check("t5_busy_write_dropped", ch_out, mkch(16'h1111));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Write+start together, dwell=0, then start+abort together.
    wr_addr = 4'd0; wr_ch_val = mkch(16'h1234); wr_cmd = 8'h00; wr_send = 1'b0;
    wr_dwell = 24'd0; wr_chk = 1'b0; wr_last = 1'b1;
    wr_en = 1'b1; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t6_new_data_used", ch_out, mkch(16'h1234));
    check("t6_dwell0_busy", busy, 1'b1);
    @(negedge clk);
    check("t6_dwell0_done", done, 1'b1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t6_abort_wins_busy", busy, 1'b0);
    check("t6_abort_wins_done", done, 1'b0);
    @(negedge clk);
    check("t6_stays_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
